// File: rtl/nonce_report_pkg.sv
// nonce_report_pkg
// Shared definitions for the nonce report transmitter: packet header bytes,
// the transmitter state type and a helper that gives the length of a nonce
// packet in bytes.
// Optional feature macro: NONCE_REPORT_SEQ_EN (adds a sequence byte to both
// packet types and accounts for it in packet_len).
package nonce_report_pkg;

    localparam logic [7:0] HDR_NONCE = 8'hA5;
    localparam logic [7:0] HDR_END   = 8'h5A;

    // ST_SEQ / ST_ESEQ are only reachable when the sequence byte is enabled.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HDR,
        ST_SEQ,
        ST_CORE,
        ST_NB,
        ST_CSUM,
        ST_END0,
        ST_ESEQ,
        ST_END1
    } tx_state_t;

    // Bytes in one nonce packet: header, [seq], core id, nonce bytes, checksum.
    function automatic int packet_len(input int nonce_bits);
`ifdef NONCE_REPORT_SEQ_EN
        return 4 + nonce_bits / 8;
`else
        return 3 + nonce_bits / 8;
`endif
    endfunction

endpackage

// File: rtl/nonce_report_ser.sv
// nonce_report_ser
// Byte serializer for the nonce report transmitter. Holds the nonce in a
// byte-lane shift register (lane 0 is the next nonce byte to send), owns the
// registered stream outputs and keeps the running XOR checksum of every byte
// accepted by the host.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   word_load      capture word_in into the lanes (MSB byte into lane 0)
//   word_in        nonce word
//   shift          advance the lanes by one byte
//   byte_load      place byte_in on the output and raise out_valid
//   byte_in        byte to present
//   byte_drop      lower out_valid (packet finished)
//   csum_clr       clear the checksum (start of packet)
//   out_ready      host ready
//   out_valid      byte available to host (registered)
//   out_data       byte to host (registered)
//   accept         out_valid && out_ready this cycle
//   head_byte      next nonce byte (lane 0)
//   csum_next      checksum including the byte currently on out_data
import nonce_report_pkg::*;

module nonce_report_ser #(
    parameter int NONCE_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  word_load,
    input  logic [NONCE_BITS-1:0] word_in,
    input  logic                  shift,
    input  logic                  byte_load,
    input  logic [7:0]            byte_in,
    input  logic                  byte_drop,
    input  logic                  csum_clr,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  accept,
    output logic [7:0]            head_byte,
    output logic [7:0]            csum_next
);

    localparam int NUM_NB = NONCE_BITS / 8;

    logic [NUM_NB-1:0][7:0] lanes_reg;
    logic [NUM_NB-1:0][7:0] lanes_next;
    logic                   out_valid_reg;
    logic [7:0]             out_data_reg;
    logic [7:0]             csum_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NB; gi++) begin : g_lane
            logic [7:0] shift_in;
            if (gi == NUM_NB - 1) begin : g_last
                assign shift_in = 8'h00;
            end else begin : g_mid
                assign shift_in = lanes_reg[gi+1];
            end
            assign lanes_next[gi] = word_load ? word_in[NONCE_BITS-1-8*gi -: 8] :
                                    shift     ? shift_in :
                                                lanes_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
            csum_reg      <= 8'h00;
        end else begin
            lanes_reg <= lanes_next;
            // The top only loads a new byte when the output is empty or the
            // current byte is being accepted, so the held byte never changes
            // under a stall.
            if (byte_load) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= byte_in;
            end else if (byte_drop) begin
                out_valid_reg <= 1'b0;
            end
            if (csum_clr) begin
                csum_reg <= 8'h00;
            end else if (accept) begin
                csum_reg <= csum_reg ^ out_data_reg;
            end
        end
    end

    assign accept    = out_valid_reg & out_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign head_byte = lanes_reg[0];
    assign csum_next = csum_reg ^ out_data_reg;

endmodule

// File: rtl/nonce_report_tx.sv
// nonce_report_tx
// Reader side of the nonce buffer: pops {core_id, nonce} entries and sends
// them to the host as framed byte packets (A5, core, nonce MSB first, XOR
// checksum) over a valid/ready byte stream. When the miner reports the job
// done and the buffer is drained, one end packet (5A 00) is sent per job.
// Optional feature macro: NONCE_REPORT_SEQ_EN inserts a wrapping 8-bit
// sequence byte after the header of both packet types.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   buf_empty    nonce buffer has no entries
//   buf_rd       pop strobe; buf_data is valid the following cycle
//   buf_data     {core_id, nonce}
//   job_done     level, miner finished the current job
//   out_valid    byte available to host
//   out_data     byte to host
//   out_ready    host accepts byte when out_valid && out_ready
import nonce_report_pkg::*;

module nonce_report_tx #(
    parameter int NONCE_BITS = 32,
    parameter int NUM_CORES  = 3,
    parameter int CORE_BITS  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            buf_empty,
    output logic                            buf_rd,
    input  logic [NONCE_BITS+CORE_BITS-1:0] buf_data,
    input  logic                            job_done,
    output logic                            out_valid,
    output logic [7:0]                      out_data,
    input  logic                            out_ready
);

    localparam int NUM_NB   = NONCE_BITS / 8;
    localparam int NB_CNT_W = (NUM_NB > 1) ? $clog2(NUM_NB) : 1;
    localparam logic [NB_CNT_W-1:0] NB_LAST = NB_CNT_W'(NUM_NB - 1);

    tx_state_t             state_reg;
    tx_state_t             state_next;
    logic [NB_CNT_W-1:0]   nb_cnt_reg;
    logic [NB_CNT_W-1:0]   nb_cnt_next;
    logic                  done_sent_reg;
    logic                  done_sent_next;
    logic [CORE_BITS-1:0]  core_reg;
`ifdef NONCE_REPORT_SEQ_EN
    logic [7:0]            seq_reg;
    logic [7:0]            seq_next;
`endif

    logic       word_load;
    logic       shift;
    logic       byte_load;
    logic [7:0] byte_in;
    logic       byte_drop;
    logic       csum_clr;
    logic       accept;
    logic [7:0] head_byte;
    logic [7:0] csum_next;

    always_comb begin
        state_next     = state_reg;
        nb_cnt_next    = nb_cnt_reg;
        // done_sent is per job: it falls as soon as job_done is released.
        done_sent_next = job_done ? done_sent_reg : 1'b0;
        buf_rd         = 1'b0;
        word_load      = 1'b0;
        shift          = 1'b0;
        byte_load      = 1'b0;
        byte_in        = 8'h00;
        byte_drop      = 1'b0;
        csum_clr       = 1'b0;
`ifdef NONCE_REPORT_SEQ_EN
        seq_next       = seq_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Pending nonces always go before the end packet.
                if (!buf_empty) begin
                    buf_rd     = rst_n;
                    state_next = ST_WAIT;
                end else if (job_done && !done_sent_reg) begin
                    byte_load  = 1'b1;
                    byte_in    = HDR_END;
                    state_next = ST_END0;
                end
            end
            ST_WAIT: begin
                word_load  = 1'b1;
                byte_load  = 1'b1;
                byte_in    = HDR_NONCE;
                csum_clr   = 1'b1;
                state_next = ST_HDR;
            end
            ST_HDR: begin
                if (accept) begin
                    byte_load  = 1'b1;
`ifdef NONCE_REPORT_SEQ_EN
                    byte_in    = seq_reg;
                    state_next = ST_SEQ;
`else
                    byte_in    = 8'(core_reg);
                    state_next = ST_CORE;
`endif
                end
            end
`ifdef NONCE_REPORT_SEQ_EN
            ST_SEQ: begin
                if (accept) begin
                    byte_load  = 1'b1;
                    byte_in    = 8'(core_reg);
                    state_next = ST_CORE;
                end
            end
`endif
            ST_CORE: begin
                if (accept) begin
                    byte_load   = 1'b1;
                    byte_in     = head_byte;
                    shift       = 1'b1;
                    nb_cnt_next = '0;
                    state_next  = ST_NB;
                end
            end
            ST_NB: begin
                if (accept) begin
                    byte_load = 1'b1;
                    if (nb_cnt_reg == NB_LAST) begin
                        // csum_next already folds in the nonce byte being accepted.
                        byte_in    = csum_next;
                        state_next = ST_CSUM;
                    end else begin
                        byte_in     = head_byte;
                        shift       = 1'b1;
                        nb_cnt_next = nb_cnt_reg + NB_CNT_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    byte_drop  = 1'b1;
                    state_next = ST_IDLE;
`ifdef NONCE_REPORT_SEQ_EN
                    seq_next   = seq_reg + 8'd1;
`endif
                end
            end
            ST_END0: begin
                if (accept) begin
                    byte_load  = 1'b1;
`ifdef NONCE_REPORT_SEQ_EN
                    byte_in    = seq_reg;
                    state_next = ST_ESEQ;
`else
                    byte_in    = 8'h00;
                    state_next = ST_END1;
`endif
                end
            end
`ifdef NONCE_REPORT_SEQ_EN
            ST_ESEQ: begin
                if (accept) begin
                    byte_load  = 1'b1;
                    byte_in    = 8'h00;
                    state_next = ST_END1;
                end
            end
`endif
            ST_END1: begin
                if (accept) begin
                    byte_drop      = 1'b1;
                    done_sent_next = 1'b1;
                    state_next     = ST_IDLE;
`ifdef NONCE_REPORT_SEQ_EN
                    seq_next       = seq_reg + 8'd1;
`endif
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            nb_cnt_reg    <= '0;
            done_sent_reg <= 1'b0;
            core_reg      <= '0;
`ifdef NONCE_REPORT_SEQ_EN
            seq_reg       <= 8'h00;
`endif
        end else begin
            state_reg     <= state_next;
            nb_cnt_reg    <= nb_cnt_next;
            done_sent_reg <= done_sent_next;
            if (word_load) begin
                core_reg <= buf_data[NONCE_BITS +: CORE_BITS];
            end
`ifdef NONCE_REPORT_SEQ_EN
            seq_reg       <= seq_next;
`endif
        end
    end

    nonce_report_ser #(
        .NONCE_BITS (NONCE_BITS)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .word_load (word_load),
        .word_in   (buf_data[NONCE_BITS-1:0]),
        .shift     (shift),
        .byte_load (byte_load),
        .byte_in   (byte_in),
        .byte_drop (byte_drop),
        .csum_clr  (csum_clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .accept    (accept),
        .head_byte (head_byte),
        .csum_next (csum_next)
    );

endmodule

// File: tb/tb_nonce_report_tx.sv
// tb_nonce_report_tx
// Directed bench for nonce_report_tx. A queue models the nonce buffer, a
// packet-level model turns each queued entry (and each expected end packet)
// into the byte list the host must see, and a single compare process checks
// every accepted byte and the stream hold rule on every cycle.
// Optional feature macro: NONCE_REPORT_SEQ_EN (sequence byte expectations).
module tb_nonce_report_tx;

    localparam int NB = 32;
    localparam int CB = 2;
`ifdef NONCE_REPORT_SEQ_EN
    localparam int SEQ_B = 1;
`else
    localparam int SEQ_B = 0;
`endif
    localparam int PKT_BYTES = 7 + SEQ_B;

    logic           clk;
    logic           rst_n;
    logic           buf_empty;
    logic           buf_rd;
    logic [NB+CB-1:0] buf_data;
    logic           job_done;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;

    logic [NB+CB-1:0] buf_q[$];
    logic [7:0]       exp_q[$];
    logic [7:0]       model_seq = 8'h00;
    logic [7:0]       acc_log [8192];
    int               acc_count    = 0;
    int               valid_cycles = 0;
    int               rd_count     = 0;
    int               ready_mode   = 0;
    logic             stall_prev   = 1'b0;
    logic [7:0]       stall_data   = 8'h00;

    nonce_report_tx #(
        .NONCE_BITS (NB),
        .NUM_CORES  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buf_empty (buf_empty),
        .buf_rd    (buf_rd),
        .buf_data  (buf_data),
        .job_done  (job_done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Host ready pattern: 0 = always ready, 1 = toggle every cycle, else stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Nonce buffer: a pop seen before an edge delivers data just after it.
    initial begin
        forever begin
            @(negedge clk);
            if (buf_rd && buf_q.size() != 0) begin
                @(posedge clk);
                #1;
                buf_data  = buf_q.pop_front();
                buf_empty = (buf_q.size() == 0);
                rd_count++;
            end
        end
    end

    // Compare process: every accepted byte against the model, hold rule, pop rule.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    checks++;
                    if (!out_valid || out_data !== stall_data) begin
                        failures++;
                        $display("FAIL stall_hold valid=%0b data=%02h required valid=1 data=%02h",
                                 out_valid, out_data, stall_data);
                    end
                end
                checks++;
                if (buf_rd && buf_empty) begin
                    failures++;
                    $display("FAIL rd_while_empty buf_rd=1 buf_empty=1");
                end
                if (out_valid) valid_cycles++;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_byte got=%02h required=none", out_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            failures++;
                            $display("FAIL byte[%0d] got=%02h required=%02h", acc_count, out_data, e);
                        end
                    end
                    acc_log[acc_count] = out_data;
                    acc_count++;
                    $display("byte[%0d] = %02h", acc_count - 1, out_data);
                end
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end else begin
            $display("ok %s = %0h", name, act);
        end
    endtask

    // Packet model: header, [seq], core, nonce MSB first, XOR of all prior bytes.
    task automatic expect_nonce(input logic [7:0] core, input logic [31:0] nonce);
        logic [7:0] b[$];
        logic [7:0] x;
        b.push_back(8'hA5);
        if (SEQ_B != 0) b.push_back(model_seq);
        b.push_back(core);
        for (int i = 3; i >= 0; i--) b.push_back(nonce[i*8 +: 8]);
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
        foreach (b[i]) exp_q.push_back(b[i]);
        model_seq = model_seq + 8'd1;
    endtask

    task automatic expect_end();
        exp_q.push_back(8'h5A);
        if (SEQ_B != 0) exp_q.push_back(model_seq);
        exp_q.push_back(8'h00);
        model_seq = model_seq + 8'd1;
    endtask

    task automatic push_entry(input logic [1:0] core, input logic [31:0] nonce);
        buf_q.push_back({core, nonce});
        buf_empty = 1'b0;
        expect_nonce({6'd0, core}, nonce);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] lit1 [PKT_BYTES];
        int base;
        int rd0;
        int vc0;
        int n;
        logic idle_ok;

`ifdef NONCE_REPORT_SEQ_EN
        lit1 = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE7};
`else
        lit1 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE7};
`endif
        rst_n     = 1'b0;
        buf_empty = 1'b1;
        buf_data  = '0;
        job_done  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_buf_rd", int'(buf_rd), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // One entry, host always ready; checksum A5^02^12^34^AB^CD = E7.
        base = acc_count;
        rd0  = rd_count;
        push_entry(2'd2, 32'h1234ABCD);
        wait_drain(100, "single");
        chk("single_rd_pulses", rd_count - rd0, 1);
        for (int i = 0; i < PKT_BYTES; i++) chk($sformatf("single_lit[%0d]", i), int'(acc_log[base+i]), int'(lit1[i]));

        // Same entry, host ready toggling every cycle.
        ready_mode = 1;
        vc0  = valid_cycles;
        base = acc_count;
        push_entry(2'd2, 32'h1234ABCD);
        wait_drain(200, "toggle");
        ready_mode = 0;
        n = valid_cycles - vc0;
        checks++;
        if (n < 2 * PKT_BYTES - 1 || n > 2 * PKT_BYTES) begin
            failures++;
            $display("FAIL toggle_cycles got=%0d required=%0d..%0d", n, 2 * PKT_BYTES - 1, 2 * PKT_BYTES);
        end else begin
            $display("ok toggle_cycles = %0d", n);
        end
        chk("toggle_last", int'(acc_log[base+PKT_BYTES-1]), 8'hE7);
        repeat (2) @(posedge clk);
        #1;

        // Three queued entries, then job_done: nonces first, then one end packet.
        push_entry(2'd0, 32'hDEADBEEF);
        push_entry(2'd1, 32'h00000001);
        push_entry(2'd2, 32'hFFFFFFFF);
        expect_end();
        job_done = 1'b1;
        wait_drain(300, "three");
        chk("end_hdr", int'(acc_log[acc_count-2-SEQ_B]), 8'h5A);
        chk("end_tail", int'(acc_log[acc_count-1]), 8'h00);
        base = acc_count;
        repeat (20) @(posedge clk);
        #1;
        chk("no_second_end", acc_count - base, 0);
        job_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_end();
        job_done = 1'b1;
        wait_drain(50, "end_again");
        job_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Idle: empty buffer, no job_done.
        idle_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (buf_rd || out_valid) idle_ok = 1'b0;
        end
        chk("idle_quiet", int'(idle_ok), 1);
        @(posedge clk);
        #1;

        // Reset while the second nonce byte is on the output.
        base = acc_count;
        push_entry(2'd1, 32'hCAFE0042);
        n = 0;
        while (acc_count < base + 3 + SEQ_B && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reset_reach_nb1", int'(acc_count >= base + 3 + SEQ_B), 1);
        ready_mode = 2;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_mid_valid", int'(out_valid), 0);
        exp_q.delete();
        model_seq  = 8'h00;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        base = acc_count;
        push_entry(2'd1, 32'h0BADF00D);
        wait_drain(100, "after_reset");
        chk("after_reset_hdr", int'(acc_log[base]), 8'hA5);
        chk("after_reset_core", int'(acc_log[base+1+SEQ_B]), 8'h01);

`ifdef NONCE_REPORT_SEQ_EN
        // Sequence byte: 00 for the packet above, 01 next, wraps after 256.
        chk("seq_first", int'(acc_log[base+1]), 8'h00);
        base = acc_count;
        push_entry(2'd0, 32'h00000002);
        wait_drain(100, "seq_second");
        chk("seq_second", int'(acc_log[base+1]), 8'h01);
        for (int k = 0; k < 255; k++) begin
            base = acc_count;
            push_entry(2'(k % 3), k);
            wait_drain(100, "seq_wrap");
        end
        chk("seq_wrap", int'(acc_log[base+1]), 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
